// File: rtl/dcache_controller_if.sv
// Core/memory-side signal bundle for the data cache controller.
// slave = controller side, master = core + memory side.
interface dcache_controller_if #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4
);
  localparam int SEL_W = $clog2(WORDS_PER_LINE);

  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] addr;
  logic              flush;
  logic              stall;
  logic              hit;
  logic              cache_we;
  logic              refill;
  logic [SEL_W-1:0]  cache_word_sel;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;

  modport slave (
    input  memRead, memWrite, addr, flush, mem_ready,
    output stall, hit, cache_we, refill, cache_word_sel,
    output mem_req, mem_we, mem_addr
  );

  modport master (
    output memRead, memWrite, addr, flush, mem_ready,
    input  stall, hit, cache_we, refill, cache_word_sel,
    input  mem_req, mem_we, mem_addr
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-through data cache sequencer (tags, valids, FSM).
// DCACHE_PERF_CNT_EN adds hit_cnt/miss_cnt lookup counters.
module dcache_controller #(
  parameter int ADDR_W         = 32,
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef DCACHE_PERF_CNT_EN
  dcache_controller_if.slave bus,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`else
  dcache_controller_if.slave bus
`endif
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [OFF_W-1:0] cnt;
  logic             hit_q;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];

  logic [TAG_W-1:0] tag_f;
  logic [IDX_W-1:0] idx_f;
  logic [OFF_W-1:0] off_f;
  logic             hit_w;
  logic             last_beat;

  assign tag_f     = bus.addr[ADDR_W-1 -: TAG_W];
  assign idx_f     = bus.addr[OFF_W+2 +: IDX_W];
  assign off_f     = bus.addr[2 +: OFF_W];
  assign hit_w     = valid[idx_f] && (tags[idx_f] == tag_f);
  assign last_beat = (cnt == OFF_W'(WORDS_PER_LINE - 1));

  logic              stall_w;
  logic              cache_we_w;
  logic              refill_w;
  logic [OFF_W-1:0]  sel_w;
  logic              mem_req_w;
  logic              mem_we_w;
  logic [ADDR_W-1:0] mem_addr_w;

  always_comb begin
    stall_w    = 1'b0;
    cache_we_w = 1'b0;
    refill_w   = 1'b0;
    sel_w      = '0;
    mem_req_w  = 1'b0;
    mem_we_w   = 1'b0;
    mem_addr_w = '0;
    unique case (state)
      S_IDLE: begin
        stall_w = rst_n && (bus.flush || bus.memWrite ||
                            (bus.memRead && !hit_w));
      end
      S_REFILL: begin
        stall_w    = 1'b1;
        mem_req_w  = 1'b1;
        mem_addr_w = {bus.addr[ADDR_W-1:OFF_W+2], cnt, 2'b00};
        if (bus.mem_ready) begin
          cache_we_w = 1'b1;
          refill_w   = 1'b1;
          sel_w      = cnt;
        end
      end
      S_WRITE: begin
        stall_w    = 1'b1;
        mem_req_w  = 1'b1;
        mem_we_w   = 1'b1;
        mem_addr_w = {bus.addr[ADDR_W-1:2], 2'b00};
        if (bus.mem_ready && hit_q) begin
          cache_we_w = 1'b1;
          sel_w      = off_f;
        end
      end
      default: ;
    endcase
  end

  assign bus.hit            = hit_w;
  assign bus.stall          = stall_w;
  assign bus.cache_we       = cache_we_w;
  assign bus.refill         = refill_w;
  assign bus.cache_word_sel = sel_w;
  assign bus.mem_req        = mem_req_w;
  assign bus.mem_we         = mem_we_w;
  assign bus.mem_addr       = mem_addr_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      hit_q <= 1'b0;
      valid <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.flush) begin
            valid <= '0;
          end else if (bus.memWrite) begin
            state <= S_WRITE;
            hit_q <= hit_w;
          end else if (bus.memRead && !hit_w) begin
            state <= S_REFILL;
            cnt   <= '0;
          end
        end
        S_REFILL: begin
          if (bus.mem_ready) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              valid[idx_f] <= 1'b1;
              state        <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag storage needs no reset: valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_REFILL && bus.mem_ready && last_beat)
      tags[idx_f] <= tag_f;
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_IDLE && !bus.flush &&
                 (bus.memRead || bus.memWrite)) begin
      if (hit_w) hit_cnt  <= hit_cnt + 32'd1;
      else       miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller.
// Define DCACHE_PERF_CNT_EN to also check the lookup counters.
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dcache_controller_if bus ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  dcache_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`else
  dcache_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, " mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, " cache_we"}, 32'(bus.cache_we), 32'd0);
  endtask

  // Load miss at a, single-cycle ready, optional flush mid-refill.
  task automatic load_miss(input logic [31:0] a, input bit flush_mid);
    bus.memRead   = 1'b1;
    bus.addr      = a;
    bus.mem_ready = 1'b0;
    #1;
    chk("lookup hit", 32'(bus.hit), 32'd0);
    chk("lookup stall", 32'(bus.stall), 32'd1);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (flush_mid) bus.flush = (i == 1 || i == 2);
      #1;
      chk("beat mem_req", 32'(bus.mem_req), 32'd1);
      chk("beat mem_we", 32'(bus.mem_we), 32'd0);
      chk("beat mem_addr", bus.mem_addr, (a & 32'hFFFF_FFF0) + 32'(4 * i));
      chk("beat cache_we", 32'(bus.cache_we), 32'd1);
      chk("beat refill", 32'(bus.refill), 32'd1);
      chk("beat sel", 32'(bus.cache_word_sel), 32'(i));
      chk("beat stall", 32'(bus.stall), 32'd1);
    end
    tick();
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("done stall", 32'(bus.stall), 32'd0);
    idle_outs("done");
    tick();
    bus.memRead = 1'b0;
    #1;
  endtask

  task automatic probe(input string tag, input logic [31:0] a,
                       input logic exp_hit);
    bus.memRead = 1'b1;
    bus.addr    = a;
    #1;
    chk({tag, " hit"}, 32'(bus.hit), 32'(exp_hit));
    chk({tag, " stall"}, 32'(!exp_hit), 32'(bus.stall));
    bus.memRead = 1'b0;
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.addr      = 32'h40;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst stall", 32'(bus.stall), 32'd0);
    chk("rst hit", 32'(bus.hit), 32'd0);
    chk("rst refill", 32'(bus.refill), 32'd0);
    chk("rst sel", 32'(bus.cache_word_sel), 32'd0);
    idle_outs("rst");
`ifdef DCACHE_PERF_CNT_EN
    chk("rst hit_cnt", hit_cnt, 32'd0);
    chk("rst miss_cnt", miss_cnt, 32'd0);
`endif

    load_miss(32'h40, 1'b0);
`ifdef DCACHE_PERF_CNT_EN
    chk("cnt miss", miss_cnt, 32'd1);
    chk("cnt hit", hit_cnt, 32'd0);
`endif
    probe("reload 48", 32'h48, 1'b1);

    // Store hit to 0x44, ready on the third WRITE cycle.
    bus.memWrite = 1'b1;
    bus.addr     = 32'h44;
    #1;
    chk("st lookup hit", 32'(bus.hit), 32'd1);
    chk("st lookup stall", 32'(bus.stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.mem_ready = (i == 2);
      #1;
      chk("st mem_req", 32'(bus.mem_req), 32'd1);
      chk("st mem_we", 32'(bus.mem_we), 32'd1);
      chk("st mem_addr", bus.mem_addr, 32'h44);
      chk("st cache_we", 32'(bus.cache_we), 32'(i == 2));
      chk("st stall", 32'(bus.stall), 32'd1);
    end
    chk("st refill", 32'(bus.refill), 32'd0);
    chk("st sel", 32'(bus.cache_word_sel), 32'd1);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("st done stall", 32'(bus.stall), 32'd0);
    idle_outs("st done");
    tick();
    bus.memWrite = 1'b0;
    #1;

    // Store miss to 0x1000: memory write only.
    bus.memWrite  = 1'b1;
    bus.addr      = 32'h1000;
    #1;
    chk("sm lookup hit", 32'(bus.hit), 32'd0);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("sm mem_addr", bus.mem_addr, 32'h1000);
    chk("sm mem_we", 32'(bus.mem_we), 32'd1);
    chk("sm cache_we", 32'(bus.cache_we), 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("sm done stall", 32'(bus.stall), 32'd0);
    tick();
    bus.memWrite = 1'b0;
    #1;
    probe("after sm 1000", 32'h1000, 1'b0);
    probe("after sm 40", 32'h40, 1'b1);

    // Conflict on index 4.
    load_miss(32'h440, 1'b0);
    probe("conflict 440", 32'h440, 1'b1);
    probe("conflict 40", 32'h40, 1'b0);

    // Flush in IDLE.
    load_miss(32'h40, 1'b0);
    probe("pre flush 40", 32'h40, 1'b1);
    bus.flush   = 1'b1;
    bus.memRead = 1'b1;
    bus.addr    = 32'h40;
    #1;
    chk("flush stall", 32'(bus.stall), 32'd1);
    tick();
    bus.flush   = 1'b0;
    bus.memRead = 1'b0;
    #1;
    probe("post flush 40", 32'h40, 1'b0);

    // Flush during REFILL is ignored.
    load_miss(32'h40, 1'b1);
    probe("flush mid 40", 32'h40, 1'b1);

    // Reset on the second refill beat.
    bus.memRead   = 1'b1;
    bus.addr      = 32'h80;
    #1;
    chk("rr lookup hit", 32'(bus.hit), 32'd0);
    bus.mem_ready = 1'b1;
    tick();
    chk("rr beat0 addr", bus.mem_addr, 32'h80);
    tick();
    chk("rr beat1 addr", bus.mem_addr, 32'h84);
    rst_n = 1'b0;
    tick();
    chk("rr mem_req", 32'(bus.mem_req), 32'd0);
    chk("rr stall", 32'(bus.stall), 32'd0);
`ifdef DCACHE_PERF_CNT_EN
    chk("rr hit_cnt", hit_cnt, 32'd0);
    chk("rr miss_cnt", miss_cnt, 32'd0);
`endif
    rst_n         = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    chk("rr 80 hit", 32'(bus.hit), 32'd0);
    chk("rr 80 stall", 32'(bus.stall), 32'd1);
    bus.memRead = 1'b0;
    #1;
    probe("rr 40", 32'h40, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
